// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spart_pkg
// Purpose  : Shared declarations for the SPART transmitter and receiver:
//            divisor width, transmit FSM state encoding, 50 MHz baud divisors
//            and the br_cfg -> divisor lookup.
// Revision : 1.0  initial release
// ============================================================================
package spart_pkg;

   localparam int DIV_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Clocks per bit at 50 MHz
   localparam logic [DIV_W-1:0] DIV_4800  = 16'd10416;
   localparam logic [DIV_W-1:0] DIV_9600  = 16'd5208;
   localparam logic [DIV_W-1:0] DIV_19200 = 16'd2604;
   localparam logic [DIV_W-1:0] DIV_38400 = 16'd1302;

   function automatic logic [DIV_W-1:0] br_cfg_to_div(input logic [1:0] br_cfg);
      logic [DIV_W-1:0] v;
      case (br_cfg)
         2'b00:   v = DIV_4800;
         2'b01:   v = DIV_9600;
         2'b10:   v = DIV_19200;
         default: v = DIV_38400;
      endcase
      return v;
   endfunction

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : spart_baud_cnt
// Purpose  : Reloadable bit-period down-counter. On load it takes div-1 and
//            counts down to 0; bit_done is high while the count is 0.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            load          - reload with div-1 at the next edge
//            div           - clocks per bit (caller guarantees >= 1)
//            bit_done      - current cycle is the last cycle of the bit
// Revision : 1.0  initial release
// ============================================================================
module spart_baud_cnt #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             bit_done
);

   logic [DIV_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         // A zero divisor would wrap; treat it as a one-cycle bit.
         r_cnt <= (div == '0) ? '0 : div - DIV_W'(1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - DIV_W'(1);
      end
   end

   assign bit_done = (r_cnt == '0);

endmodule : spart_baud_cnt
`default_nettype wire

// File: rtl/spart_tx.sv
`default_nettype none
// ============================================================================
// Module   : spart_tx
// Purpose  : SPART transmitter. Sends 8N1 frames (start, 8 data LSB first,
//            stop) with a one-byte holding register (THR) ahead of the shift
//            register (TSR) so frames can run back to back.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            tx_data       - byte to send, taken when tx_wr && tbr
//            tx_wr         - single-cycle write strobe
//            divisor       - clocks per bit, latched at frame load (0 => 1)
//            tbr           - holding register empty
//            tx_busy       - a frame is in progress
//            txd           - registered serial output, idle high
// Revision : 1.0  initial release
// ============================================================================
module spart_tx #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       tx_data,
   input  logic             tx_wr,
   input  logic [DIV_W-1:0] divisor,
   output logic             tbr,
   output logic             tx_busy,
   output logic             txd
);

   import spart_pkg::*;

   tx_state_t        r_state;
   tx_state_t        w_state_next;
   logic [7:0]       r_thr;
   logic             r_thr_full;
   logic [7:0]       r_tsr;
   logic [7:0]       w_tsr_next;
   logic [2:0]       r_bit_idx;
   logic [DIV_W-1:0] r_div;
   logic             r_txd;

   logic             w_bit_done;
   logic             w_load_frame;
   logic             w_shift;
   logic             w_cnt_load;
   logic             w_idx_clr;
   logic             w_idx_inc;
   logic             w_wr_accept;
   logic [DIV_W-1:0] w_div_eff;
   logic [DIV_W-1:0] w_cnt_div;

   assign w_wr_accept = tx_wr && !r_thr_full;
   assign w_div_eff   = (divisor == '0) ? DIV_W'(1) : divisor;
   // On a frame load the counter must see the freshly sampled divisor,
   // since r_div only updates at the same edge.
   assign w_cnt_div   = w_load_frame ? w_div_eff : r_div;

   spart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
      .clk      (clk),
      .rst      (rst),
      .load     (w_cnt_load),
      .div      (w_cnt_div),
      .bit_done (w_bit_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load_frame = 1'b0;
      w_shift      = 1'b0;
      w_cnt_load   = 1'b0;
      w_idx_clr    = 1'b0;
      w_idx_inc    = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_thr_full) begin
               w_load_frame = 1'b1;
               w_cnt_load   = 1'b1;
               w_state_next = START;
            end
         end
         START: begin
            if (w_bit_done) begin
               w_cnt_load   = 1'b1;
               w_idx_clr    = 1'b1;
               w_state_next = DATA;
            end
         end
         DATA: begin
            if (w_bit_done) begin
               w_shift    = 1'b1;
               w_cnt_load = 1'b1;
               if (r_bit_idx == 3'd7) begin
                  w_state_next = STOP;
               end else begin
                  w_idx_inc = 1'b1;
               end
            end
         end
         STOP: begin
            if (w_bit_done) begin
               if (r_thr_full) begin
                  // Chain straight into the next start bit.
                  w_load_frame = 1'b1;
                  w_cnt_load   = 1'b1;
                  w_state_next = START;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase

      w_tsr_next = r_tsr;
      if (w_load_frame) begin
         w_tsr_next = r_thr;
      end else if (w_shift) begin
         w_tsr_next = {1'b0, r_tsr[7:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_thr      <= '0;
         r_thr_full <= 1'b0;
         r_tsr      <= '0;
         r_bit_idx  <= '0;
         r_div      <= DIV_W'(1);
         r_txd      <= 1'b1;
      end else begin
         // Accept and load are exclusive: a load needs THR full, which
         // blocks acceptance in the same cycle.
         if (w_wr_accept) begin
            r_thr      <= tx_data;
            r_thr_full <= 1'b1;
         end else if (w_load_frame) begin
            r_thr_full <= 1'b0;
         end

         r_tsr <= w_tsr_next;

         if (w_load_frame) begin
            r_div <= w_div_eff;
         end

         if (w_idx_clr) begin
            r_bit_idx <= '0;
         end else if (w_idx_inc) begin
            r_bit_idx <= r_bit_idx + 3'd1;
         end

         // txd reflects the state being entered, so it is registered
         // without adding a cycle of latency.
         case (w_state_next)
            START:   r_txd <= 1'b0;
            DATA:    r_txd <= w_tsr_next[0];
            default: r_txd <= 1'b1;
         endcase
      end
   end

   assign txd     = r_txd;
   assign tbr     = !r_thr_full;
   assign tx_busy = (r_state != IDLE);

endmodule : spart_tx
`default_nettype wire
